// File: rtl/reu_ram_arbiter.sv
// reu_ram_arbiter
// Arbitrates three byte-wide requesters (0 = REU, 1 = GeoRAM/cartridge RAM,
// 2 = host loader) onto the single external expansion-RAM controller port.
// One pending request is picked, issued to memory, and after the memory
// acknowledge the winner gets a fixed WIN_LEN-clock `cycle` window with the
// read data held stable. One idle RECOVER clock follows every window.
//
// Configuration macro:
//   RAM_ARB_RR_EN  defined   -> round-robin arbitration, search starts at
//                               (last winner + 1) mod 3
//                  undefined -> fixed priority, port 0 > port 1 > port 2
//
// Handshake: `req` is a level; a requester holds req/addr/we/wdata stable
// until the first clock its `cycle` bit is high. Inputs are sampled only in
// IDLE. On the memory side `mem_req` is a one-clock launch strobe and
// `mem_ack` is a one-clock completion strobe with `mem_rdata` valid in that
// same clock; an ack arriving outside WAIT is ignored.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req[2:0], we[2:0]            per-port request level / write enable
//   addr0..addr2 [24:0]          per-port byte address
//   wdata0..wdata2 [7:0]         per-port write data
//   cycle[2:0]                   per-port grant window (one-hot or zero)
//   rdata[7:0]                   shared read data, valid while cycle != 0
//   mem_req/addr/we/wdata        latched access towards the memory controller
//   mem_ack, mem_rdata[7:0]      completion strobe and read data from memory
//   busy                         high whenever the FSM is not in IDLE
//   gnt_idx[1:0]                 current or last winner
module reu_ram_arbiter #(
    parameter int WIN_LEN = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [24:0] addr0,
    input  logic [24:0] addr1,
    input  logic [24:0] addr2,
    input  logic [2:0]  we,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    input  logic [7:0]  wdata2,
    output logic [2:0]  cycle,
    output logic [7:0]  rdata,
    output logic        mem_req,
    output logic [24:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic [1:0]  gnt_idx
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_WINDOW  = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    localparam logic [2:0] WIN_LAST = 3'(WIN_LEN - 1);

    state_t      state, state_nxt;
    logic [2:0]  win_cnt;
    logic [1:0]  win_idx;

    // ---------------- winner selection ----------------
`ifdef RAM_ARB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand0, cand1, cand2;

    // Candidate order rr_ptr, rr_ptr+1, rr_ptr+2, all modulo 3.
    always_comb begin
        cand0 = rr_ptr;
        cand1 = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;
        cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
        if (req[cand0])      win_idx = cand0;
        else if (req[cand1]) win_idx = cand1;
        else                 win_idx = cand2;
    end

    // Pointer moves only when a grant is actually made.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= 2'd0;
        end else if (state == ST_IDLE && req != 3'b000) begin
            rr_ptr <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
        end
    end
`else
    always_comb begin
        if (req[0])      win_idx = 2'd0;
        else if (req[1]) win_idx = 2'd1;
        else             win_idx = 2'd2;
    end
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (req != 3'b000)        state_nxt = ST_ISSUE;
            ST_ISSUE:                             state_nxt = ST_WAIT;
            ST_WAIT:    if (mem_ack)              state_nxt = ST_WINDOW;
            ST_WINDOW:  if (win_cnt == WIN_LAST)  state_nxt = ST_RECOVER;
            ST_RECOVER:                           state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cycle   = 3'b000;
        mem_req = 1'b0;
        busy    = (state != ST_IDLE);
        if (state == ST_WINDOW) begin
            case (gnt_idx)
                2'd0:    cycle = 3'b001;
                2'd1:    cycle = 3'b010;
                default: cycle = 3'b100;
            endcase
        end
        if (state == ST_ISSUE) mem_req = 1'b1;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= 25'd0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'd0;
            gnt_idx   <= 2'd0;
            rdata     <= 8'hFF;
            win_cnt   <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 3'b000) begin
                        gnt_idx <= win_idx;
                        mem_we  <= we[win_idx];
                        case (win_idx)
                            2'd0: begin
                                mem_addr  <= addr0;
                                mem_wdata <= wdata0;
                            end
                            2'd1: begin
                                mem_addr  <= addr1;
                                mem_wdata <= wdata1;
                            end
                            default: begin
                                mem_addr  <= addr2;
                                mem_wdata <= wdata2;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        win_cnt <= 3'd0;
                        // Writes leave the previous read data visible.
                        if (!mem_we) rdata <= mem_rdata;
                    end
                end
                ST_WINDOW: win_cnt <= win_cnt + 3'd1;
                default: ;
            endcase
        end
    end

    // ---------------- invariants ----------------
    a_cycle_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(cycle));
    a_mem_req_issue: assert property (@(posedge clk) disable iff (!reset_n)
        mem_req |-> (state == ST_ISSUE));

endmodule
